// File: rtl/global_defs.sv
// Shared definitions for the trace-driven DRAM front end.
//   parsed_op_t       : opcode produced by the trace parser
//   REQ_QUEUE_DEPTH   : default number of entries in request_queue
//   SKIP_IDLE_DEFAULT : default for request_queue idle time-skip mode
package global_defs;

  typedef enum logic [1:0] {
    OP_READ     = 2'd0,
    OP_WRITE    = 2'd1,
    OP_PREFETCH = 2'd2,
    OP_FLUSH    = 2'd3
  } parsed_op_t;

  localparam int unsigned REQ_QUEUE_DEPTH   = 16;
  localparam bit          SKIP_IDLE_DEFAULT = 1'b1;

endpackage

// File: rtl/request_queue_fifo.sv
// Generic synchronous FIFO storage for request_queue.
// First-word-fall-through: rd_data always shows the entry at the read pointer.
//   clk, rst_n  : clock, synchronous active-low reset
//   wr_en       : write request (ignored while full)
//   wr_data     : entry to write
//   rd_en       : read (pop) request (ignored while empty)
//   rd_data     : current head entry (undefined content while empty)
//   occupancy   : number of valid entries, 0..DEPTH
//   full, empty : decoded from occupancy
module request_queue_fifo
  import global_defs::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = REQ_QUEUE_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (occupancy == FULL_COUNT);
  assign empty   = (occupancy == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Storage carries no reset; stale contents are unreachable once the
  // pointers and occupancy are cleared.
  always_ff @(posedge clk) begin
    if (rst_n && do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/request_queue.sv
// Timed request queue between the trace parser and the DRAM scheduler.
// Buffers parsed ops in order and releases the head only once the internal
// cycle counter has reached the op's arrival cycle.
//   clk, rst_n       : clock, synchronous active-low reset
//   in_valid/ready   : parser handshake; in_opcode/in_address/in_time = op
//   out_valid/ready  : scheduler handshake; out_* = head op (0 when empty)
//   cycle_count      : current simulated cycle (saturating)
//   occupancy        : valid entries; full/empty decoded from it
//   order_err        : sticky, set when an accepted in_time goes backwards
module request_queue
  import global_defs::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned TIME_WIDTH    = 32,
  parameter int unsigned DEPTH         = REQ_QUEUE_DEPTH,
  parameter bit          SKIP_IDLE     = SKIP_IDLE_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  parsed_op_t               in_opcode,
  input  logic [ADDRESS_WIDTH-1:0] in_address,
  input  logic [TIME_WIDTH-1:0]    in_time,
  output logic                     out_valid,
  input  logic                     out_ready,
  output parsed_op_t               out_opcode,
  output logic [ADDRESS_WIDTH-1:0] out_address,
  output logic [TIME_WIDTH-1:0]    out_time,
  output logic [TIME_WIDTH-1:0]    cycle_count,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     full,
  output logic                     empty,
  output logic                     order_err
);

  typedef struct packed {
    parsed_op_t               opcode;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [TIME_WIDTH-1:0]    arrival;
  } entry_t;

  localparam int unsigned ENTRY_W = $bits(entry_t);

  entry_t              wr_entry;
  entry_t              head;
  logic [ENTRY_W-1:0]  head_bits;
  logic                enq;
  logic                deq;
  logic                skip;
  logic [TIME_WIDTH:0] cc_plus1;
  logic [TIME_WIDTH-1:0] last_time;

  assign wr_entry = '{opcode: in_opcode, address: in_address, arrival: in_time};
  assign head     = entry_t'(head_bits);

  assign in_ready = !full;
  assign enq      = in_valid && in_ready;
  assign deq      = out_valid && out_ready;

  request_queue_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (enq),
    .wr_data   (wr_entry),
    .rd_en     (deq),
    .rd_data   (head_bits),
    .occupancy (occupancy),
    .full      (full),
    .empty     (empty)
  );

  // Release is gated by reset so nothing is handed out in a reset cycle.
  assign out_valid   = rst_n && !empty && (head.arrival <= cycle_count);
  assign out_opcode  = empty ? parsed_op_t'('0) : head.opcode;
  assign out_address = empty ? '0 : head.address;
  assign out_time    = empty ? '0 : head.arrival;

  // One extra bit so cycle_count + 1 cannot wrap when the counter is at max.
  assign cc_plus1 = {1'b0, cycle_count} + 1'b1;
  assign skip     = SKIP_IDLE && !empty && ({1'b0, head.arrival} > cc_plus1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_count <= '0;
    end else if (skip) begin
      cycle_count <= head.arrival;
    end else if (cycle_count != '1) begin
      cycle_count <= cycle_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_time <= '0;
      order_err <= 1'b0;
    end else if (enq) begin
      last_time <= in_time;
      if (in_time < last_time) order_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_request_queue.sv
// Bench for request_queue: two instances (no skip / idle skip) share inputs.
// A queue-level reference model predicts every output of both after each edge;
// a directed vector table and hand-written sequences cover the corner cases.
module tb_request_queue;
  import global_defs::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned HIST  = 8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, out_ready;
  parsed_op_t  in_opcode;
  logic [31:0] in_address, in_time;

  logic        o_in_ready[2], o_out_valid[2], o_full[2], o_empty[2], o_order_err[2];
  parsed_op_t  o_opcode[2];
  logic [31:0] o_address[2], o_time[2], o_cc[2];
  logic [4:0]  o_occ[2];

  request_queue #(.ADDRESS_WIDTH(32), .TIME_WIDTH(32), .DEPTH(DEPTH), .SKIP_IDLE(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o_in_ready[0]),
    .in_opcode(in_opcode), .in_address(in_address), .in_time(in_time),
    .out_valid(o_out_valid[0]), .out_ready(out_ready), .out_opcode(o_opcode[0]),
    .out_address(o_address[0]), .out_time(o_time[0]), .cycle_count(o_cc[0]),
    .occupancy(o_occ[0]), .full(o_full[0]), .empty(o_empty[0]), .order_err(o_order_err[0]));

  request_queue #(.ADDRESS_WIDTH(32), .TIME_WIDTH(32), .DEPTH(DEPTH), .SKIP_IDLE(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o_in_ready[1]),
    .in_opcode(in_opcode), .in_address(in_address), .in_time(in_time),
    .out_valid(o_out_valid[1]), .out_ready(out_ready), .out_opcode(o_opcode[1]),
    .out_address(o_address[1]), .out_time(o_time[1]), .cycle_count(o_cc[1]),
    .occupancy(o_occ[1]), .full(o_full[1]), .empty(o_empty[1]), .order_err(o_order_err[1]));

  // Reference model: every accepted op is appended to a history list; the
  // queue is the slice [head, tail). Time is tracked as a wide integer.
  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] t;
  } rec_t;

  rec_t            hist[2][HIST];
  int unsigned     m_head[2], m_tail[2];
  longint unsigned m_cc[2];
  logic [31:0]     m_last[2];
  logic            m_oerr[2];

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      int unsigned occ;
      rec_t        h;
      logic        hv;
      occ = m_tail[d] - m_head[d];
      h   = (occ != 0) ? hist[d][m_head[d]] : '0;
      hv  = (occ != 0) && (longint'(h.t) <= m_cc[d]);
      if (!rst_n) begin
        m_head[d] = 0; m_tail[d] = 0; m_cc[d] = 0; m_last[d] = '0; m_oerr[d] = 1'b0;
      end else begin
        if (in_valid && occ != DEPTH) begin
          if (m_tail[d] >= HIST - 1) begin
            $display("FAIL model history overflow: got %0d expected below %0d", m_tail[d], HIST);
            $fatal(1);
          end
          hist[d][m_tail[d]] = {in_opcode, in_address, in_time};
          m_tail[d]++;
          if (in_time < m_last[d]) m_oerr[d] = 1'b1;
          m_last[d] = in_time;
        end
        if (hv && out_ready) m_head[d]++;
        if (d == 1 && occ != 0 && longint'(h.t) > m_cc[d] + 1) m_cc[d] = longint'(h.t);
        else if (m_cc[d] < 64'hFFFF_FFFF) m_cc[d]++;
      end
    end
  endtask

  task automatic check_model();
    for (int d = 0; d < 2; d++) begin
      int unsigned occ;
      rec_t        h;
      logic        ev;
      occ = m_tail[d] - m_head[d];
      h   = (occ != 0) ? hist[d][m_head[d]] : '0;
      ev  = (occ != 0) && (longint'(h.t) <= m_cc[d]);
      chk($sformatf("dut%0d in_ready", d), o_in_ready[d], occ != DEPTH);
      chk($sformatf("dut%0d out_valid", d), o_out_valid[d], ev);
      chk($sformatf("dut%0d out_opcode", d), o_opcode[d], h.op);
      chk($sformatf("dut%0d out_address", d), o_address[d], h.addr);
      chk($sformatf("dut%0d out_time", d), o_time[d], h.t);
      chk($sformatf("dut%0d cycle_count", d), o_cc[d], m_cc[d]);
      chk($sformatf("dut%0d occupancy", d), o_occ[d], occ);
      chk($sformatf("dut%0d full", d), o_full[d], occ == DEPTH);
      chk($sformatf("dut%0d empty", d), o_empty[d], occ == 0);
      chk($sformatf("dut%0d order_err", d), o_order_err[d], m_oerr[d]);
    end
  endtask

  // One clock: drive inputs (caller is at a falling edge), advance the model,
  // then check everything at the next falling edge.
  task automatic tick(input bit r, input bit v, input logic [1:0] op,
                      input logic [31:0] a, input logic [31:0] t, input bit rdy);
    rst_n = r; in_valid = v; in_opcode = parsed_op_t'(op);
    in_address = a; in_time = t; out_ready = rdy;
    model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic idle(input int unsigned n, input bit rdy);
    for (int unsigned i = 0; i < n; i++) tick(1'b1, 1'b0, 2'd0, 32'h0, 32'h0, rdy);
  endtask

  typedef struct {
    bit          r, v;
    logic [1:0]  op;
    logic [31:0] a, t;
    bit          rdy;
    bit          e_valid;
    logic [4:0]  e_occ;
    logic [31:0] e_cc, e_addr;
  } vec_t;

  vec_t        vt[10];
  logic [31:0] expq[$];
  bit          seen;

  initial begin
    // Directed vectors against the non-skipping instance.
    vt[0] = '{1'b0, 1'b0, 2'd0, 32'h0,         32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 32'h0};
    vt[1] = '{1'b1, 1'b0, 2'd0, 32'h0,         32'd0, 1'b0, 1'b0, 5'd0, 32'd1, 32'h0};
    vt[2] = '{1'b1, 1'b0, 2'd0, 32'h0,         32'd0, 1'b0, 1'b0, 5'd0, 32'd2, 32'h0};
    vt[3] = '{1'b1, 1'b0, 2'd0, 32'h0,         32'd0, 1'b0, 1'b0, 5'd0, 32'd3, 32'h0};
    vt[4] = '{1'b1, 1'b1, 2'd0, 32'h0000_1000, 32'd0, 1'b0, 1'b1, 5'd1, 32'd4, 32'h0000_1000};
    vt[5] = '{1'b1, 1'b0, 2'd0, 32'h0,         32'd0, 1'b1, 1'b0, 5'd0, 32'd5, 32'h0};
    vt[6] = '{1'b1, 1'b1, 2'd1, 32'hDEAD_BEE0, 32'd8, 1'b0, 1'b0, 5'd1, 32'd6, 32'hDEAD_BEE0};
    vt[7] = '{1'b1, 1'b0, 2'd0, 32'h0,         32'd0, 1'b0, 1'b0, 5'd1, 32'd7, 32'hDEAD_BEE0};
    vt[8] = '{1'b1, 1'b0, 2'd0, 32'h0,         32'd0, 1'b0, 1'b1, 5'd1, 32'd8, 32'hDEAD_BEE0};
    vt[9] = '{1'b1, 1'b0, 2'd0, 32'h0,         32'd0, 1'b1, 1'b0, 5'd0, 32'd9, 32'h0};
    for (int i = 0; i < 10; i++) begin
      tick(vt[i].r, vt[i].v, vt[i].op, vt[i].a, vt[i].t, vt[i].rdy);
      chk($sformatf("vec%0d out_valid", i), o_out_valid[0], vt[i].e_valid);
      chk($sformatf("vec%0d occupancy", i), o_occ[0], vt[i].e_occ);
      chk($sformatf("vec%0d cycle_count", i), o_cc[0], vt[i].e_cc);
      chk($sformatf("vec%0d out_address", i), o_address[0], vt[i].e_addr);
    end

    // Reset, idle 20 cycles, then a one-cycle reset.
    tick(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
    idle(20, 1'b0);
    chk("idle20 cycle_count", o_cc[0], 32'd20);
    chk("idle20 empty", o_empty[0], 1'b1);
    chk("idle20 in_ready", o_in_ready[0], 1'b1);
    chk("idle20 out_valid", o_out_valid[0], 1'b0);
    tick(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
    chk("rst cycle_count dut0", o_cc[0], 32'd0);
    chk("rst cycle_count dut1", o_cc[1], 32'd0);

    // Idle skip to a far arrival time versus plain counting.
    idle(2, 1'b0);
    tick(1'b1, 1'b1, 2'd1, 32'hDEAD_BEE0, 32'd500, 1'b0);
    idle(1, 1'b0);
    chk("skip cycle_count", o_cc[1], 32'd500);
    chk("skip out_valid", o_out_valid[1], 1'b1);
    chk("skip out_address", o_address[1], 32'hDEAD_BEE0);
    chk("noskip cycle_count", o_cc[0], 32'd4);
    chk("noskip out_valid early", o_out_valid[0], 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      if (o_out_valid[0]) seen = 1'b1;
      else idle(1, 1'b0);
    end
    chk("noskip release seen", seen, 1'b1);
    chk("noskip release cycle", o_cc[0], 32'd500);
    idle(1, 1'b1);
    chk("skip drained dut0", o_empty[0], 1'b1);
    chk("skip drained dut1", o_empty[1], 1'b1);

    // Head due exactly next cycle: no skip, counter simply increments.
    tick(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
    tick(1'b1, 1'b1, 2'd2, 32'h0000_0044, 32'd2, 1'b0);
    idle(1, 1'b0);
    chk("near head cycle_count", o_cc[1], 32'd2);
    chk("near head out_valid", o_out_valid[1], 1'b1);

    // Skip to the maximum time, then the counter saturates.
    tick(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
    tick(1'b1, 1'b1, 2'd3, 32'h0000_0F00, 32'hFFFF_FFFF, 1'b0);
    idle(1, 1'b0);
    chk("saturate skip", o_cc[1], 32'hFFFF_FFFF);
    idle(2, 1'b0);
    chk("saturate hold", o_cc[1], 32'hFFFF_FFFF);
    chk("saturate out_valid", o_out_valid[1], 1'b1);

    // Fill to full, reject a 17th op, drain in order, refill across the wrap.
    tick(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
    for (int k = 0; k < 16; k++) tick(1'b1, 1'b1, 2'(k), 32'h100 + 32'(k * 4), 32'(k), 1'b0);
    chk("fill full", o_full[0], 1'b1);
    chk("fill in_ready", o_in_ready[0], 1'b0);
    chk("fill occupancy", o_occ[0], 5'd16);
    tick(1'b1, 1'b1, 2'd0, 32'h0000_0BAD, 32'd0, 1'b0);
    chk("fill reject 17th", o_occ[0], 5'd16);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("drain%0d address", k), o_address[0], 32'h100 + 32'(k * 4));
      tick(1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 1'b1);
    end
    chk("drain empty", o_empty[0], 1'b1);
    for (int k = 0; k < 8; k++) tick(1'b1, 1'b1, 2'd1, 32'h200 + 32'(k), 32'd20, 1'b0);
    chk("refill occupancy", o_occ[0], 5'd8);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("refill%0d address", k), o_address[0], 32'h200 + 32'(k));
      tick(1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 1'b1);
    end

    // Steady streaming at occupancy 5.
    tick(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
    expq.delete();
    for (int k = 0; k < 5; k++) begin
      tick(1'b1, 1'b1, 2'd0, 32'h400 + 32'(k), 32'd0, 1'b0);
      expq.push_back(32'h400 + 32'(k));
    end
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("stream%0d address", k), o_address[0], expq[0]);
      void'(expq.pop_front());
      expq.push_back(32'h500 + 32'(k));
      tick(1'b1, 1'b1, 2'd1, 32'h500 + 32'(k), 32'd0, 1'b1);
      chk($sformatf("stream%0d occupancy", k), o_occ[0], 5'd5);
    end

    // Arrival order violation: sticky flag, ops still delivered in order.
    tick(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
    tick(1'b1, 1'b1, 2'd0, 32'h0000_00A0, 32'd100, 1'b0);
    chk("order ok after first", o_order_err[0], 1'b0);
    tick(1'b1, 1'b1, 2'd1, 32'h0000_00B0, 32'd90, 1'b0);
    chk("order_err set", o_order_err[0], 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (o_out_valid[0]) seen = 1'b1;
      else idle(1, 1'b0);
    end
    chk("order first released", seen, 1'b1);
    chk("order first address", o_address[0], 32'h0000_00A0);
    idle(1, 1'b1);
    chk("order second address", o_address[0], 32'h0000_00B0);
    chk("order second valid", o_out_valid[0], 1'b1);
    idle(1, 1'b1);
    chk("order drained", o_empty[0], 1'b1);
    chk("order_err sticky", o_order_err[0], 1'b1);
    tick(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
    chk("order_err cleared", o_order_err[0], 1'b0);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      longint unsigned base;
      int unsigned     lo;
      logic [31:0]     tv;
      base = m_cc[0];
      lo   = $urandom_range(0, 48);
      tv   = (base + lo >= 8) ? 32'(base + lo - 8) : 32'd0;
      tick($urandom_range(0, 199) != 0, ($urandom % 3) != 0, 2'($urandom_range(0, 3)),
           $urandom, tv, ($urandom % 4) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
